// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// Imported by the parser and by anything that decodes its command format.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        RD_CNT  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_SEND = 3'd5
    } state_e;

    localparam int         WR_BIT   = 7;
    localparam logic [8:0] CNT_ZERO = 9'd256;

endpackage

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: first byte selects read/write and start address,
// then write data bytes or a read count; reads stream register data to the UART tx.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_block_timeout,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    input  logic              tx_busy,
    output logic              tx_data_valid,
    output logic [7:0]        tx_data
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        txd_q, txd_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              txv_q, txv_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        txv_d   = 1'b0;

        // The write strobe is out this cycle; advance for the next data byte.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (rx_data_valid) begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    state_d = rx_data[WR_BIT] ? WR_DATA : RD_CNT;
                end
            end
            WR_DATA: begin
                if (rx_data_valid) begin
                    wr_en_d = 1'b1;
                    wdata_d = rx_data;
                end
            end
            RD_CNT: begin
                if (rx_data_valid) begin
                    cnt_d   = (rx_data == 8'd0) ? CNT_ZERO : {1'b0, rx_data};
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                rd_en_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Read data appears the cycle after the strobe drops.
                if (!rd_en_q) begin
                    txd_d   = reg_rdata;
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                if (!tx_busy) begin
                    txv_d   = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? IDLE : RD_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Burst end drops any partial command once this cycle's byte is taken.
        if (rx_block_timeout &&
            (state_q == IDLE || state_q == WR_DATA || state_q == RD_CNT)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            txv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            txv_q   <= txv_d;
        end
    end

    assign reg_wr_en     = wr_en_q;
    assign reg_rd_en     = rd_en_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign tx_data_valid = txv_q;
    assign tx_data       = txd_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed command scenarios plus random
// read/write bursts checked against a transaction-level register model.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_block_timeout = 1'b0;
    logic       reg_wr_en, reg_rd_en, tx_data_valid;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata, tx_data;
    logic [7:0] reg_rdata = 8'h00;
    logic       tx_busy;
    logic       busy_force = 1'b0;
    logic       busy_rand = 1'b0;
    logic       rnd_busy = 1'b0;

    logic [7:0] mem [128];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int rd_cnt = 0;
    int viol = 0;
    int tx_cyc = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_lat_q[$];
    int tx_q[$];

    uart_cmd_parser #(.ADDR_W(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data_valid(rx_data_valid),
        .rx_data(rx_data),
        .rx_block_timeout(rx_block_timeout),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .tx_busy(tx_busy),
        .tx_data_valid(tx_data_valid),
        .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    assign tx_busy = busy_force | (busy_rand & rnd_busy);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd_busy <= 1'($urandom_range(0, 1));
        if (reg_rd_en) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clk) begin
        if (rx_data_valid) last_rx_cyc <= cyc;
        if (reg_wr_en) begin
            wr_addr_q.push_back(int'(reg_addr));
            wr_data_q.push_back(int'(reg_wdata));
            wr_lat_q.push_back(cyc - last_rx_cyc);
        end
        if (reg_rd_en) rd_cnt <= rd_cnt + 1;
        if (tx_data_valid) begin
            tx_q.push_back(int'(tx_data));
            tx_cyc <= cyc;
        end
        if (int'(reg_wr_en) + int'(reg_rd_en) + int'(tx_data_valid) > 1)
            viol <= viol + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit to);
        rx_data          = b;
        rx_data_valid    = 1'b1;
        rx_block_timeout = to;
        idle(1);
        rx_data_valid    = 1'b0;
        rx_block_timeout = 1'b0;
        rx_data          = 8'h00;
    endtask

    task automatic timeout_pulse();
        rx_block_timeout = 1'b1;
        idle(1);
        rx_block_timeout = 1'b0;
    endtask

    task automatic wait_tx(input int want);
        int k = 0;
        int budget = want * 24 + 100;
        while (tx_q.size() < want && k < budget) begin
            idle(1);
            k++;
        end
        idle(3);
        check("tx_count", tx_q.size(), want);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, int'(reg_wr_en), 0);
        check({tag, "_rd_en"}, int'(reg_rd_en), 0);
        check({tag, "_addr"}, int'(reg_addr), 0);
        check({tag, "_wdata"}, int'(reg_wdata), 0);
        check({tag, "_txv"}, int'(tx_data_valid), 0);
        check({tag, "_txd"}, int'(tx_data), 0);
    endtask

    // Reference: a read of n from a streams mem[a], mem[a+1], ... mod 128.
    task automatic do_read(input int a, input int cnt_byte, input int gap);
        int base = tx_q.size();
        int n = (cnt_byte == 0) ? 256 : cnt_byte;
        send_byte(8'(a & 8'h7f), 1'b0);
        idle(gap);
        send_byte(8'(cnt_byte), 1'b0);
        wait_tx(base + n);
        for (int i = 0; i < n; i++) begin
            if (base + i < tx_q.size())
                check($sformatf("rd_a%0h_i%0d", a, i), tx_q[base + i],
                      int'(mem[(a + i) % 128]));
        end
    endtask

    task automatic do_write(input int a, input int n, input bit conc);
        int base = wr_addr_q.size();
        int d [$];
        send_byte(8'(8'h80 | a), 1'b0);
        for (int i = 0; i < n; i++) begin
            d.push_back(int'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
            send_byte(8'(d[i]), conc && (i == n - 1));
        end
        if (!conc) begin
            idle(1);
            timeout_pulse();
        end
        idle(3);
        check("wr_count", wr_addr_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wr_addr_q.size()) begin
                check($sformatf("wr_addr_%0d", i), wr_addr_q[base + i], (a + i) % 128);
                check($sformatf("wr_data_%0d", i), wr_data_q[base + i], d[i]);
            end
        end
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rd0, rel;

        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 8'h40);

        #3;
        check_outputs_zero("reset");
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check_outputs_zero("post_reset");

        // Write burst with address increment, then timeout.
        base = wr_addr_q.size();
        send_byte(8'h85, 1'b0);
        idle(1);
        send_byte(8'hAA, 1'b0);
        idle(2);
        send_byte(8'hBB, 1'b0);
        idle(1);
        timeout_pulse();
        idle(3);
        check("w1_count", wr_addr_q.size() - base, 2);
        if (wr_addr_q.size() >= base + 2) begin
            check("w1_addr0", wr_addr_q[base], 8'h05);
            check("w1_data0", wr_data_q[base], 8'hAA);
            check("w1_lat0", wr_lat_q[base], 1);
            check("w1_addr1", wr_addr_q[base + 1], 8'h06);
            check("w1_data1", wr_data_q[base + 1], 8'hBB);
            check("w1_lat1", wr_lat_q[base + 1], 1);
        end

        // Address wrap at the top of the map.
        base = wr_addr_q.size();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        timeout_pulse();
        idle(3);
        check("w2_count", wr_addr_q.size() - base, 2);
        if (wr_addr_q.size() >= base + 2) begin
            check("w2_addr0", wr_addr_q[base], 8'h7F);
            check("w2_data0", wr_data_q[base], 8'h11);
            check("w2_addr1", wr_addr_q[base + 1], 8'h00);
            check("w2_data1", wr_data_q[base + 1], 8'h22);
            check("w2_lat1", wr_lat_q[base + 1], 1);
        end

        // Read of 3, with junk and a timeout injected mid-read.
        base = tx_q.size();
        send_byte(8'h10, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h85, 1'b1);
        wait_tx(base + 3);
        if (tx_q.size() >= base + 3) begin
            check("r1_b0", tx_q[base], 8'h50);
            check("r1_b1", tx_q[base + 1], 8'h51);
            check("r1_b2", tx_q[base + 2], 8'h52);
        end
        base = wr_addr_q.size();
        send_byte(8'h33, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_tx(tx_q.size() + 1);
        check("r1_idle_after", tx_q[tx_q.size() - 1], 8'h73);
        check("r1_no_write", wr_addr_q.size() - base, 0);

        // Backpressure: hold busy 50 cycles, one pulse on release.
        base = tx_q.size();
        busy_force = 1'b1;
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(50);
        check("bp_no_pulse", tx_q.size() - base, 0);
        check("bp_held", int'(tx_data), 8'h60);
        busy_force = 1'b0;
        rel = cyc;
        idle(10);
        check("bp_pulses", tx_q.size() - base, 1);
        if (tx_q.size() > base) check("bp_byte", tx_q[base], 8'h60);
        check("bp_pulse_cyc", tx_cyc - rel, 1);

        // Aborted write command, then a fresh read command.
        base = wr_addr_q.size();
        rd0 = rd_cnt;
        send_byte(8'h90, 1'b0);
        idle(2);
        timeout_pulse();
        idle(2);
        send_byte(8'h01, 1'b0);
        idle(3);
        check("ab_no_write", wr_addr_q.size() - base, 0);
        check("ab_no_read", rd_cnt - rd0, 0);
        base = tx_q.size();
        send_byte(8'h02, 1'b0);
        wait_tx(base + 2);
        if (tx_q.size() >= base + 2) begin
            check("ab_b0", tx_q[base], 8'h41);
            check("ab_b1", tx_q[base + 1], 8'h42);
        end

        // Reset during RD_SEND of a 4-byte read.
        base = tx_q.size();
        busy_force = 1'b1;
        send_byte(8'h30, 1'b0);
        send_byte(8'h04, 1'b0);
        idle(10);
        rst_n = 1'b0;
        #2;
        check_outputs_zero("mid_rst");
        busy_force = 1'b0;
        idle(3);
        rd0 = rd_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("mid_rst_no_tx", tx_q.size() - base, 0);
        check("mid_rst_no_rd", rd_cnt - rd0, 0);
        do_read(8'h7E, 3, 0);

        // Random bursts against the model.
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 255));
        busy_rand = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int a = int'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            end else begin
                int c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
                do_read(a, c, int'($urandom_range(0, 3)));
            end
            idle(int'($urandom_range(0, 3)));
        end
        busy_rand = 1'b0;

        check("onehot_viol", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 7, register address width.
REQ-002 The block SHALL have the port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port rx_data_valid, input, 1 bit: one-cycle pulse marking a received byte.
REQ-005 The block SHALL have the port rx_data, input, 8 bits: received byte, valid while rx_data_valid is high.
REQ-006 The block SHALL have the port rx_block_timeout, input, 1 bit: one-cycle pulse marking the end of a UART burst.
REQ-007 The block SHALL have the port reg_wr_en, output, 1 bit: register write strobe.
REQ-008 The block SHALL have the port reg_rd_en, output, 1 bit: register read strobe.
REQ-009 The block SHALL have the port reg_addr, output, ADDR_W bits: register address for both the write and the read strobes.
REQ-010 The block SHALL have the port reg_wdata, output, 8 bits: write data, valid while reg_wr_en is high.
REQ-011 The block SHALL have the port reg_rdata, input, 8 bits: read data, valid the cycle after reg_rd_en.
REQ-012 The block SHALL have the port tx_busy, input, 1 bit: the downstream transmitter cannot accept a byte.
REQ-013 The block SHALL have the port tx_data_valid, output, 1 bit: one-cycle pulse that loads tx_data into the transmitter.
REQ-014 The block SHALL have the port tx_data, output, 8 bits: byte to transmit.

Function
REQ-015 First byte of a burst: bit7=1 selects write, bit7=0 selects read; bits[ADDR_W-1:0] are the start address.
REQ-016 The block SHALL implement the states IDLE, WR_DATA, RD_CNT, RD_REQ, RD_WAIT and RD_SEND.
REQ-017 IDLE + rx_data_valid: latch the address; go to WR_DATA if bit7=1, otherwise go to RD_CNT.
REQ-018 WR_DATA + rx_data_valid: on the next cycle pulse reg_wr_en for one cycle with reg_wdata equal to the byte; then increment the address.
REQ-019 Address increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-020 RD_CNT + rx_data_valid: load the read count N from the byte (0 means 256) and go to RD_REQ.
REQ-021 RD_REQ SHALL pulse reg_rd_en for one cycle at the current address and go to RD_WAIT.
REQ-022 RD_WAIT SHALL capture reg_rdata into tx_data one cycle later and go to RD_SEND.
REQ-023 RD_SEND with tx_busy=0: pulse tx_data_valid for one cycle, increment the address (with wrap), decrement N; go to IDLE if N reaches 0, otherwise go to RD_REQ.
REQ-024 RD_SEND with tx_busy=1: hold tx_data and wait.
REQ-025 rx_block_timeout in WR_DATA or RD_CNT SHALL return the block to IDLE, discarding the partial command.
REQ-026 rx_block_timeout in IDLE SHALL have no effect.
REQ-027 While in RD_REQ, RD_WAIT or RD_SEND, rx_data_valid and rx_block_timeout SHALL be ignored; the read completes all N bytes.
REQ-028 If rx_data_valid and rx_block_timeout occur in the same cycle, the byte is processed first and the state then becomes IDLE; a write byte in that cycle is still written.
REQ-029 At most one of reg_wr_en, reg_rd_en and tx_data_valid SHALL be high in any cycle.
REQ-030 Write latency SHALL be exactly 1 cycle from rx_data_valid to reg_wr_en.

Reset
REQ-031 On rst_n low, the state SHALL be IDLE and all outputs and internal registers (address, N, tx_data, reg_wdata) SHALL be 0, asynchronously.
REQ-032 Reset mid-read SHALL abandon the read with no further strobes or tx pulses.
REQ-033 The first clock edge after reset release SHALL behave as IDLE.

Structure
REQ-034 The state enum, the write-bit index (7) and the count-zero-means-256 constant SHALL live in the shared package uart_cmd_pkg.
REQ-035 The block SHALL have no sub-modules; inputs come from the synchronous uart_rx domain, so no synchronizer is needed.

Verification
REQ-036 Bytes 0x85,0xAA,0xBB then timeout -> reg_wr_en at addr 0x05 with data 0xAA, then at addr 0x06 with data 0xBB; IDLE after timeout.
REQ-037 Bytes 0xFF,0x11,0x22 -> writes to addr 0x7F with data 0x11, then addr 0x00 with data 0x22 (wrap).
REQ-038 Bytes 0x10,0x03 with reg_rdata=addr+0x40 and tx_busy=0 -> tx bytes 0x50,0x51,0x52, then IDLE.
REQ-039 Read of 0x20 count 1 with tx_busy held high for 50 cycles -> tx_data=rdata is held, and tx_data_valid pulses once, on the first cycle tx_busy is low.
REQ-040 Byte 0x90 then timeout, then byte 0x01 -> no write and no read occurs, and 0x01 is decoded as a new read command at addr 0x01.
REQ-041 rst_n asserted during RD_SEND with count 4 -> all outputs 0 immediately and no further tx pulses.
